// File: rtl/missile_pkg.sv
// missile_pkg: shared slot states, screen geometry and sprite-ROM frame helper
package missile_pkg;
    typedef enum logic [1:0] {S_IDLE, S_FLY, S_BOOM} slot_state_t;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    function automatic logic [15:0] sprite_base(input logic boom, input int size_x, input int size_y);
        return boom ? 16'(size_x * size_y) : 16'd0;
    endfunction
endpackage

// File: rtl/missile_slot.sv
// missile_slot: one missile FSM with its position, explosion timer and pixel test
module missile_slot
    import missile_pkg::*;
#(
    parameter int SIZE_X = 12,
    parameter int SIZE_Y = 40,
    parameter int Y_STEP = 7,
    parameter int Y_OFFSET = 38,
    parameter int FLOOR_Y = 400,
    parameter int EXPLODE_FRAMES = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        tick,
    input  logic        alloc,
    input  logic        alive,
    input  logic [9:0]  start_x,
    input  logic [9:0]  start_y,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic        busy,
    output logic        hit,
    output logic        boom,
    output logic        entered_boom,
    output logic [15:0] addr
);
    localparam int CW = EXPLODE_FRAMES > 1 ? $clog2(EXPLODE_FRAMES) : 1;
    localparam logic signed [10:0] SX = 11'(SIZE_X);
    localparam logic signed [10:0] SY = 11'(SIZE_Y);
    localparam logic [10:0] HX = 11'(SIZE_X / 2);
    slot_state_t state;
    logic [9:0] x, y;
    logic [CW-1:0] cnt;
    logic [10:0] y_next;
    logic signed [10:0] lx, ly;
    assign y_next = {1'b0, y} + 11'(Y_STEP);
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
            x <= '0;
            y <= '0;
            cnt <= '0;
            entered_boom <= 1'b0;
        end else begin
            entered_boom <= 1'b0;
            if (!alive) begin
                state <= S_IDLE;
            end else if (alloc) begin
                state <= S_FLY;
                x <= start_x;
                y <= start_y + 10'(Y_OFFSET);
            end else if (tick && state == S_FLY) begin
                if (y_next >= 11'(FLOOR_Y)) begin
                    y <= 10'(FLOOR_Y);
                    cnt <= CW'(EXPLODE_FRAMES - 1);
                    state <= S_BOOM;
                    entered_boom <= 1'b1;
                end else begin
                    y <= y_next[9:0];
                end
            end else if (tick && state == S_BOOM) begin
                if (cnt == CW'(0)) state <= S_IDLE;
                else cnt <= cnt - CW'(1);
            end
        end
    end
    assign busy = state != S_IDLE;
    assign boom = state == S_BOOM;
    // sprite is anchored at its bottom-centre; signed offsets reject pixels left/above
    assign lx = {1'b0, DrawX} - {1'b0, x} + HX;
    assign ly = {1'b0, DrawY} - {1'b0, y} + 11'(SIZE_Y);
    assign hit = busy && !lx[10] && lx < SX && !ly[10] && ly < SY;
    assign addr = 16'(ly[9:0]) * 16'(SIZE_X) + 16'(lx[9:0]) + sprite_base(boom, SIZE_X, SIZE_Y);
endmodule

// File: rtl/missile_pool.sv
// missile_pool: allocates launches to free missile slots and muxes their pixel hits
module missile_pool
    import missile_pkg::*;
#(
    parameter int NUM_MISSILES = 4,
    parameter int SIZE_X = 12,
    parameter int SIZE_Y = 40,
    parameter int Y_STEP = 7,
    parameter int Y_OFFSET = 38,
    parameter int FLOOR_Y = 400,
    parameter int EXPLODE_FRAMES = 8,
    localparam int HW = NUM_MISSILES > 1 ? $clog2(NUM_MISSILES) : 1
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    frame_clk,
    input  logic                    launch,
    input  logic [9:0]              start_x,
    input  logic [9:0]              start_y,
    input  logic                    alive,
    input  logic [9:0]              DrawX,
    input  logic [9:0]              DrawY,
    output logic                    launch_ack,
    output logic                    full,
    output logic [NUM_MISSILES-1:0] active_mask,
    output logic                    explode_pulse,
    output logic                    is_missile,
    output logic                    exploding,
    output logic [HW-1:0]           hit_slot,
    output logic [15:0]             addr
);
    logic fc_q, tick, grant, found;
    logic [NUM_MISSILES-1:0] busy, hit, boom, entered, alloc;
    logic [15:0] slot_addr [NUM_MISSILES];
    logic [HW-1:0] free_idx, win;
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fc_q <= 1'b0;
            tick <= 1'b0;
            launch_ack <= 1'b0;
        end else begin
            fc_q <= frame_clk;
            tick <= frame_clk & ~fc_q;
            launch_ack <= grant;
        end
    end
    assign full = &busy;
    assign active_mask = busy;
    assign explode_pulse = |entered;
    assign grant = launch && alive && !full;
    // descending scan so the lowest index wins both allocation and display priority
    always_comb begin
        free_idx = '0;
        win = '0;
        found = 1'b0;
        for (int i = NUM_MISSILES - 1; i >= 0; i--) begin
            if (!busy[i]) free_idx = HW'(i);
            if (hit[i]) begin
                win = HW'(i);
                found = 1'b1;
            end
        end
        alloc = grant ? NUM_MISSILES'(1) << free_idx : '0;
    end
    assign is_missile = alive && found;
    assign exploding = is_missile && boom[win];
    assign hit_slot = is_missile ? win : '0;
    assign addr = is_missile ? slot_addr[win] : 16'd0;
    for (genvar s = 0; s < NUM_MISSILES; s++) begin : g_slot
        missile_slot #(
            .SIZE_X(SIZE_X), .SIZE_Y(SIZE_Y), .Y_STEP(Y_STEP), .Y_OFFSET(Y_OFFSET),
            .FLOOR_Y(FLOOR_Y), .EXPLODE_FRAMES(EXPLODE_FRAMES)
        ) u_slot (
            .Clk(Clk),
            .Reset(Reset),
            .tick(tick),
            .alloc(alloc[s]),
            .alive(alive),
            .start_x(start_x),
            .start_y(start_y),
            .DrawX(DrawX),
            .DrawY(DrawY),
            .busy(busy[s]),
            .hit(hit[s]),
            .boom(boom[s]),
            .entered_boom(entered[s]),
            .addr(slot_addr[s])
        );
    end
endmodule

// File: tb/tb_missile_pool.sv
// tb_missile_pool: randomized scoreboard bench against a behavioural missile-pool model
module tb_missile_pool;
    localparam int N = 4;
    logic Clk = 1'b0, Reset = 1'b1, frame_clk = 1'b0, launch = 1'b0, alive = 1'b1;
    logic [9:0] start_x = '0, start_y = '0, DrawX = '0, DrawY = '0;
    logic launch_ack, full, explode_pulse, is_missile, exploding;
    logic [N-1:0] active_mask;
    logic [1:0] hit_slot;
    logic [15:0] addr;

    missile_pool dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .launch(launch),
        .start_x(start_x), .start_y(start_y), .alive(alive), .DrawX(DrawX), .DrawY(DrawY),
        .launch_ack(launch_ack), .full(full), .active_mask(active_mask),
        .explode_pulse(explode_pulse), .is_missile(is_missile), .exploding(exploding),
        .hit_slot(hit_slot), .addr(addr)
    );

    always #10 Clk = ~Clk;

    int errors = 0, checks = 0, cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // model: per slot 0 = free, 1 = falling, 2 = exploding, with ticks of explosion left
    int m_st[N], m_x[N], m_y[N], m_left[N];
    bit m_fc, m_tick;
    typedef struct {int edge_n; logic [N-1:0] mask;} ack_t;
    ack_t ack_q[$];
    int boom_q[$];
    bit fix_px = 0;
    int fix_x, fix_y;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [N-1:0] m_mask();
        logic [N-1:0] m;
        for (int i = 0; i < N; i++) m[i] = m_st[i] != 0;
        return m;
    endfunction

    function automatic bit any_boom();
        for (int i = 0; i < N; i++) if (m_st[i] == 2) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_st[i] = 0; m_x[i] = 0; m_y[i] = 0; m_left[i] = 0;
        end
        m_fc = 0; m_tick = 0;
        ack_q.delete();
        boom_q.delete();
    endtask

    // predicts the effect of the coming clock edge using the inputs now applied
    task automatic model_edge();
        int pick = -1;
        bit blew = 0;
        if (!alive) begin
            for (int i = 0; i < N; i++) m_st[i] = 0;
        end else begin
            for (int i = 0; i < N; i++) if (m_st[i] == 0 && pick < 0) pick = i;
            if (!launch) pick = -1;
            for (int i = 0; i < N; i++) begin
                if (i == pick) begin
                    m_st[i] = 1; m_x[i] = start_x; m_y[i] = (start_y + 38) % 1024;
                end else if (m_tick && m_st[i] == 1) begin
                    if (m_y[i] + 7 >= 400) begin
                        m_y[i] = 400; m_st[i] = 2; m_left[i] = 8; blew = 1;
                    end else m_y[i] = m_y[i] + 7;
                end else if (m_tick && m_st[i] == 2) begin
                    m_left[i]--;
                    if (m_left[i] == 0) m_st[i] = 0;
                end
            end
            if (pick >= 0) ack_q.push_back('{cyc + 1, m_mask()});
            if (blew) boom_q.push_back(cyc + 1);
        end
        m_tick = frame_clk && !m_fc;
        m_fc = frame_clk;
    endtask

    task automatic step(input bit l, input bit a, input bit fc, input int sx, input int sy);
        int dx, dy, k;
        @(negedge Clk);
        #2;
        launch = l; alive = a; frame_clk = fc;
        start_x = 10'(sx); start_y = 10'(sy);
        model_edge();
        if (fix_px) begin
            dx = fix_x; dy = fix_y; fix_px = 0;
        end else if ($urandom_range(0, 3) != 0 && m_mask() != 0) begin
            do k = $urandom_range(0, N - 1); while (m_st[k] == 0);
            dx = m_x[k] - 7 + $urandom_range(0, 14);
            dy = m_y[k] - 41 + $urandom_range(0, 42);
        end else begin
            dx = $urandom_range(0, 639);
            dy = $urandom_range(0, 519);
        end
        DrawX = 10'(dx < 0 ? 0 : dx);
        DrawY = 10'(dy < 0 ? 0 : dy);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mask"}, 32'(active_mask), 0);
        check({tag, "_full"}, 32'(full), 0);
        check({tag, "_ack"}, 32'(launch_ack), 0);
        check({tag, "_explode"}, 32'(explode_pulse), 0);
        check({tag, "_is_missile"}, 32'(is_missile), 0);
        check({tag, "_exploding"}, 32'(exploding), 0);
        check({tag, "_hit_slot"}, 32'(hit_slot), 0);
        check({tag, "_addr"}, 32'(addr), 0);
    endtask

    // monitor: scoreboard pops on DUT pulses, plus per-cycle state and pixel checks
    always @(negedge Clk) begin
        if (!Reset) begin
            bit eh, eb, ea, ee;
            int es, ead, lx, ly;
            eh = 0; eb = 0; es = 0; ead = 0;
            for (int i = 0; i < N; i++) begin
                lx = int'(DrawX) - (m_x[i] - 6);
                ly = int'(DrawY) - (m_y[i] - 40);
                if (!eh && alive && m_st[i] != 0 && lx >= 0 && lx < 12 && ly >= 0 && ly < 40) begin
                    eh = 1; es = i; eb = m_st[i] == 2;
                    ead = ly * 12 + lx + (eb ? 480 : 0);
                end
            end
            check("active_mask", 32'(active_mask), 32'(m_mask()));
            check("full", 32'(full), 32'(&m_mask()));
            check("is_missile", 32'(is_missile), 32'(eh));
            check("exploding", 32'(exploding), 32'(eb));
            check("hit_slot", 32'(hit_slot), 32'(es));
            check("addr", 32'(addr), 32'(ead));
            ea = ack_q.size() > 0 && ack_q[0].edge_n == cyc;
            if (launch_ack || ea) begin
                check("launch_ack", 32'(launch_ack), 32'(ea));
                if (ea) begin
                    check("ack_mask", 32'(active_mask), 32'(ack_q[0].mask));
                    void'(ack_q.pop_front());
                end
            end
            ee = boom_q.size() > 0 && boom_q[0] == cyc;
            if (explode_pulse || ee) begin
                check("explode_pulse", 32'(explode_pulse), 32'(ee));
                if (ee) void'(boom_q.pop_front());
            end
        end
    end

    initial begin
        int k;
        model_reset();
        #1 check_reset_outputs("reset");
        repeat (2) @(negedge Clk);
        #2 Reset = 1'b0;
        // single flight from (320,100) through explosion and back to idle
        fix_px = 1; fix_x = 314; fix_y = 98;
        step(1, 1, 0, 320, 100);
        for (int i = 0; i < 220; i++) step(0, 1, (i % 4) < 2, 0, 0);
        // five back-to-back launches into four slots
        for (int i = 0; i < 5; i++) step(1, 1, 0, $urandom_range(0, 639), $urandom_range(0, 300));
        for (int i = 0; i < 6; i++) step(0, 1, (i % 4) < 2, 0, 0);
        // alive dropped with slots active
        step(1, 0, 0, 50, 50);
        step(0, 1, 0, 0, 0);
        // launch coinciding with a tick while slot0 flies
        step(1, 1, 0, 200, 100);
        k = 0;
        while (k < 10) begin
            if (m_tick) break;
            step(0, 1, (k % 4) < 2, 0, 0);
            k++;
        end
        check("tick_found", 32'(m_tick), 1);
        step(1, 1, 0, 400, 120);
        // slot near the left edge: lx=3, no wrap
        step(1, 1, 0, 3, 200);
        fix_px = 1; fix_x = 0; fix_y = 198;
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        // random traffic
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 7) == 0, $urandom_range(0, 99) != 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 639), $urandom_range(0, 479));
        // asynchronous reset mid-explosion
        step(0, 0, 0, 0, 0);
        step(1, 1, 0, 100, 350);
        k = 0;
        while (k < 600 && !any_boom()) begin
            step(0, 1, (k % 4) < 2, 0, 0);
            k++;
        end
        check("boom_reached", 32'(any_boom()), 1);
        #3 Reset = 1'b1;
        launch = 1'b0;
        #1 check_reset_outputs("async_reset");
        model_reset();
        @(negedge Clk);
        #2 Reset = 1'b0;
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0);
        check("ack_queue_empty", 32'(ack_q.size()), 0);
        check("boom_queue_empty", 32'(boom_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
